scr_link_ctrl: RTL and testbench

//  Link sequencer for a ScramblerDescrambler pair (CHK_MODE=0 Tx, CHK_MODE=1 Rx).

---
 rtl/scr_link_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_scr_link_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr_link_ctrl.sv
// rtl/scr_link_ctrl.sv - link sequencer for a self-synchronising scrambler/descrambler pair
//
// Trains the link, forwards user words with idle-fill once locked, watches idle beats
// for errors and retrains on loss of lock.
//
// Ports
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   tx_data_i        user word to send
//   tx_valid_i       tx_data_i valid
//   tx_ready_o       word accepted this cycle (high only in DATA)
//   scr_en_o         EN to scrambler and descrambler; a cycle with it high is a beat
//   scr_data_in_o    scrambler DATA_IN
//   dsc_data_out_i   descrambler DATA_OUT
//   rx_data_o        recovered word (pass-through of dsc_data_out_i)
//   rx_valid_o       rx_data_o holds a user word
//   retrain_i        one-cycle request to force a resync
//   locked_o         link locked (state is DATA)
//   train_to_o       one-cycle pulse on training timeout
//   state_o          0 IDLE, 1 TRAIN, 2 DATA, 3 RESYNC
module scr_link_ctrl #(
    parameter int               NBITS       = 8,
    parameter int               POLY_LENGHT = 16,
    parameter int               PIPE_LAT    = 2,
    parameter logic [NBITS-1:0] TRAIN_WORD  = 8'hA5,
    parameter int               LOCK_CNT    = 8,
    parameter int               ERR_MAX     = 4,
    parameter int               TRAIN_LEN   = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NBITS-1:0] tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic             scr_en_o,
    output logic [NBITS-1:0] scr_data_in_o,
    input  logic [NBITS-1:0] dsc_data_out_i,
    output logic [NBITS-1:0] rx_data_o,
    output logic             rx_valid_o,
    input  logic             retrain_i,
    output logic             locked_o,
    output logic             train_to_o,
    output logic [1:0]       state_o
);

    // Beats before the descrambler output can be trusted: the LFSR must fill with
    // scrambled training symbols, then the pair latency has to elapse.
    localparam int FLUSH = (POLY_LENGHT + NBITS - 1) / NBITS + PIPE_LAT;

    localparam int BW = $clog2(TRAIN_LEN);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int EW = $clog2(ERR_MAX + 1);
    localparam int RW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TRAIN  = 2'd1,
        S_DATA   = 2'd2,
        S_RESYNC = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       b_q, b_d;
    logic [MW-1:0]       match_q, match_d;
    logic [EW-1:0]       err_q, err_d;
    logic [RW-1:0]       rs_q, rs_d;
    logic                train_to_q, train_to_d;
    logic                locked_q;
    logic [PIPE_LAT-1:0] dat_pipe_q, dat_pipe_d;
    logic [PIPE_LAT-1:0] chk_pipe_q, chk_pipe_d;

    logic             scr_en;
    logic [NBITS-1:0] scr_data;
    logic             tx_ready;
    logic             push_dat;
    logic             push_chk;
    logic             dsc_match;
    logic             pipe_dat_out;
    logic             pipe_chk_out;

    // The flag pipe mirrors the scrambler pair's latency so its output describes
    // whatever word is currently on dsc_data_out_i.
    assign pipe_dat_out = dat_pipe_q[PIPE_LAT-1];
    assign pipe_chk_out = chk_pipe_q[PIPE_LAT-1];
    assign dsc_match    = (dsc_data_out_i == TRAIN_WORD);

    always_comb begin
        state_d    = state_q;
        b_d        = b_q;
        match_d    = match_q;
        err_d      = err_q;
        rs_d       = rs_q;
        train_to_d = 1'b0;
        scr_en     = 1'b0;
        scr_data   = '0;
        tx_ready   = 1'b0;
        push_dat   = 1'b0;
        push_chk   = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_TRAIN;
                b_d     = '0;
                match_d = '0;
                err_d   = '0;
            end

            S_TRAIN: begin
                scr_en   = 1'b1;
                scr_data = TRAIN_WORD;
                push_chk = 1'b1;
                if (b_q != BW'(TRAIN_LEN - 1)) begin
                    b_d = b_q + 1'b1;
                end
                // Only count matches once the descrambler has been flushed.
                if (b_q >= BW'(FLUSH)) begin
                    if (dsc_match) begin
                        if (match_q != MW'(LOCK_CNT)) begin
                            match_d = match_q + 1'b1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                if (retrain_i) begin
                    state_d = S_RESYNC;
                    rs_d    = '0;
                end else if (match_d == MW'(LOCK_CNT)) begin
                    state_d = S_DATA;
                    err_d   = '0;
                end else if (b_q == BW'(TRAIN_LEN - 1)) begin
                    b_d        = '0;
                    match_d    = '0;
                    train_to_d = 1'b1;
                end
            end

            S_DATA: begin
                scr_en   = 1'b1;
                tx_ready = 1'b1;
                if (tx_valid_i) begin
                    scr_data = tx_data_i;
                    push_dat = 1'b1;
                end else begin
                    scr_data = TRAIN_WORD;
                    push_chk = 1'b1;
                end
                // Idle-fill beats are known words, so they double as a link monitor.
                if (pipe_chk_out) begin
                    if (dsc_match) begin
                        err_d = '0;
                    end else if (err_q != EW'(ERR_MAX)) begin
                        err_d = err_q + 1'b1;
                    end
                end
                if (retrain_i || (err_d == EW'(ERR_MAX))) begin
                    state_d = S_RESYNC;
                    rs_d    = '0;
                end
            end

            S_RESYNC: begin
                // Keep beating long enough for in-flight user words to drain.
                scr_en   = 1'b1;
                scr_data = TRAIN_WORD;
                if (rs_q == RW'(PIPE_LAT - 1)) begin
                    state_d = S_TRAIN;
                    b_d     = '0;
                    match_d = '0;
                    err_d   = '0;
                end else begin
                    rs_d = rs_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        dat_pipe_d = dat_pipe_q;
        chk_pipe_d = chk_pipe_q;
        if (scr_en) begin
            dat_pipe_d[0] = push_dat;
            chk_pipe_d[0] = push_chk;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dat_pipe_d[i] = dat_pipe_q[i-1];
                chk_pipe_d[i] = chk_pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            b_q        <= '0;
            match_q    <= '0;
            err_q      <= '0;
            rs_q       <= '0;
            train_to_q <= 1'b0;
            locked_q   <= 1'b0;
            dat_pipe_q <= '0;
            chk_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            b_q        <= b_d;
            match_q    <= match_d;
            err_q      <= err_d;
            rs_q       <= rs_d;
            train_to_q <= train_to_d;
            locked_q   <= (state_d == S_DATA);
            dat_pipe_q <= dat_pipe_d;
            chk_pipe_q <= chk_pipe_d;
        end
    end

    assign tx_ready_o    = tx_ready;
    assign scr_en_o      = scr_en;
    assign scr_data_in_o = scr_data;
    assign rx_data_o     = dsc_data_out_i;
    assign rx_valid_o    = pipe_dat_out & scr_en;
    assign locked_o      = locked_q;
    assign train_to_o    = train_to_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_scr_link_ctrl.sv
// tb/tb_scr_link_ctrl.sv - randomized self-checking bench for scr_link_ctrl
module tb_scr_link_ctrl;

    localparam int         NBITS       = 8;
    localparam int         POLY_LENGHT = 16;
    localparam int         PIPE_LAT    = 2;
    localparam int         LOCK_CNT    = 8;
    localparam int         ERR_MAX     = 4;
    localparam int         TRAIN_LEN   = 32;
    localparam logic [7:0] TW          = 8'hA5;
    localparam int         FLUSH       = (POLY_LENGHT + NBITS - 1) / NBITS + PIPE_LAT;
    localparam int         LOCK_EDGES  = FLUSH + LOCK_CNT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       scr_en;
    logic [7:0] scr_data_in;
    logic [7:0] dsc_out;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       retrain;
    logic       locked;
    logic       train_to;
    logic [1:0] state;

    // Channel: the scrambler pair seen as a PIPE_LAT-beat delay line, with a forced
    // stuck-at-zero mode and a bit flip held for the beats a self-sync descrambler
    // smears a single channel error over.
    logic [7:0] ch0, ch1;
    logic       force0;
    logic       flip;

    int   total;
    int   bad;
    int   beat_n;
    int   edge_n;
    int   rx_seen;
    logic acc;
    int   exp_d[$];
    int   exp_due[$];
    int   trace[$];
    int   last_st;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) begin
            ch0 <= 8'h00;
            ch1 <= 8'h00;
        end else if (scr_en) begin
            ch0 <= scr_data_in;
            ch1 <= ch0;
        end
    end

    assign dsc_out = force0 ? 8'h00 : (ch1 ^ {7'b0, flip});

    scr_link_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .tx_data_i      (tx_data),
        .tx_valid_i     (tx_valid),
        .tx_ready_o     (tx_ready),
        .scr_en_o       (scr_en),
        .scr_data_in_o  (scr_data_in),
        .dsc_data_out_i (dsc_out),
        .rx_data_o      (rx_data),
        .rx_valid_o     (rx_valid),
        .retrain_i      (retrain),
        .locked_o       (locked),
        .train_to_o     (train_to),
        .state_o        (state)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: scoreboard work at the falling edge, inputs may change 1ns
    // after the rising edge.  Accepted words must reappear exactly PIPE_LAT beats later.
    task automatic tick();
        bit due;
        @(negedge clk);
        acc = 1'b0;
        if (!rst_n) begin
            exp_d.delete();
            exp_due.delete();
        end else if (scr_en) begin
            due = (exp_due.size() > 0) && (exp_due[0] == beat_n);
            chk("rx_valid", int'(rx_valid), int'(due));
            if (due) begin
                chk("rx_data", int'(rx_data), exp_d[0]);
                void'(exp_d.pop_front());
                void'(exp_due.pop_front());
                rx_seen++;
            end
            acc = tx_valid && tx_ready;
            chk("scr_data_in", int'(scr_data_in), acc ? int'(tx_data) : int'(TW));
            if (acc) begin
                exp_d.push_back(int'(tx_data));
                exp_due.push_back(beat_n + PIPE_LAT);
            end
            beat_n++;
        end else begin
            chk("rx_valid_nobeat", int'(rx_valid), 0);
        end
        @(posedge clk);
        #1;
        edge_n++;
        if (int'(state) != last_st) begin
            trace.push_back(int'(state));
            last_st = int'(state);
        end
    endtask

    task automatic idle(input int n);
        tx_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            tx_data = 8'($urandom);
            tick();
        end
    endtask

    task automatic send(input logic [7:0] d);
        int k;
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        k = 1;
        while (!acc && k < 200) begin
            tick();
            k++;
        end
        chk("send_accept", int'(acc), 1);
        tx_valid = 1'b0;
    endtask

    task automatic wait_state(input int st, input int budget, input string tag);
        int k;
        k = 0;
        while (int'(state) != st && k < budget) begin
            tick();
            k++;
        end
        chk(tag, int'(state), st);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_tx_ready"}, int'(tx_ready), 0);
        chk({tag, "_scr_en"}, int'(scr_en), 0);
        chk({tag, "_scr_data"}, int'(scr_data_in), 0);
        chk({tag, "_rx_valid"}, int'(rx_valid), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_train_to"}, int'(train_to), 0);
    endtask

    initial begin
        int r0;
        int pulses[$];
        int exp_tr[3];
        int rs_at;
        int n;
        logic lock_seen;

        total = 0; bad = 0; beat_n = 0; edge_n = 0; rx_seen = 0; last_st = 0;
        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; retrain = 1'b0;
        force0 = 1'b0; flip = 1'b0; acc = 1'b0;

        // Reset state, then train on a clean loopback.
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n  = 1'b1;
        edge_n = 0;
        tick();
        chk("state_edge1", int'(state), 1);
        chk("train_tx_ready", int'(tx_ready), 0);
        chk("train_locked", int'(locked), 0);
        wait_state(2, 40, "first_lock");
        chk("lock_edge", edge_n, 1 + LOCK_EDGES);
        chk("locked_after_lock", int'(locked), 1);

        // Back-to-back burst 0x00..0x1D.
        r0 = rx_seen;
        for (int i = 0; i < 30; i++) send(8'(i));
        idle(PIPE_LAT + 2);
        chk("burst_rx_count", rx_seen - r0, 30);

        // Single channel errors on idle beats must not drop lock; random traffic after.
        for (int r = 0; r < 3; r++) begin
            idle($urandom_range(6, 12));
            flip = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("lock_hold_flip", int'(locked), 1);
            end
            flip = 1'b0;
            for (int i = 0; i < 6; i++) begin
                tick();
                chk("lock_hold_after", int'(locked), 1);
            end
            n = $urandom_range(5, 10);
            for (int i = 0; i < n; i++) begin
                send(8'($urandom));
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
            end
        end
        idle(6);

        // Stuck channel: four bad idle beats drop lock; release relocks.
        force0 = 1'b1;
        for (int k = 1; k <= ERR_MAX; k++) begin
            tick();
            chk("err_state", int'(state), (k < ERR_MAX) ? 2 : 3);
        end
        chk("err_locked", int'(locked), 0);
        chk("err_tx_ready", int'(tx_ready), 0);
        force0 = 1'b0;
        edge_n = 0;
        wait_state(1, 10, "resync_to_train");
        chk("resync_len", edge_n, PIPE_LAT);
        wait_state(2, 40, "relock");
        chk("relock_edge", edge_n, PIPE_LAT + LOCK_EDGES);

        // Stuck through training: periodic timeout pulses, never locks.
        idle(4);
        force0 = 1'b1;
        wait_state(3, 10, "force_resync");
        wait_state(1, 10, "force_train");
        edge_n = 0;
        lock_seen = 1'b0;
        for (int k = 0; k < 3 * TRAIN_LEN + 4; k++) begin
            tick();
            if (train_to) pulses.push_back(edge_n);
            if (locked) lock_seen = 1'b1;
        end
        chk("to_pulse_count", pulses.size(), 3);
        for (int j = 0; j < 3; j++) begin
            chk("to_pulse_edge", (j < pulses.size()) ? pulses[j] : -1, (j + 1) * TRAIN_LEN);
        end
        chk("to_no_lock", int'(lock_seen), 0);
        force0 = 1'b0;
        wait_state(2, 80, "relock_after_to");

        // RETRAIN in the middle of a 10-word burst.
        idle(4);
        trace.delete();
        last_st = int'(state);
        r0 = rx_seen;
        rs_at = $urandom_range(2, 7);
        for (int i = 0; i < 10; i++) begin
            if (i == rs_at) retrain = 1'b1;
            send(8'($urandom));
            retrain = 1'b0;
        end
        idle(PIPE_LAT + 2);
        chk("retrain_rx_count", rx_seen - r0, 10);
        exp_tr = '{3, 1, 2};
        chk("retrain_trace_len", trace.size(), 3);
        for (int j = 0; j < 3; j++) begin
            chk("retrain_trace", (j < trace.size()) ? trace[j] : -1, exp_tr[j]);
        end

        // Asynchronous reset in the middle of a burst.
        n = $urandom_range(3, 8);
        for (int i = 0; i < n; i++) send(8'($urandom));
        tx_data  = 8'($urandom);
        tx_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        tx_valid = 1'b0;
        tick();
        tick();
        rst_n  = 1'b1;
        edge_n = 0;
        wait_state(2, 40, "lock_after_reset");
        chk("lock_edge_after_reset", edge_n, 1 + LOCK_EDGES);
        for (int i = 0; i < 8; i++) send(8'($urandom));
        idle(PIPE_LAT + 2);
        chk("scoreboard_empty", exp_d.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
